logic_cluster: RTL and testbench

- Parametrised successor to the single logic block: a cluster of N basic logic elements (BLEs).
- Each BLE has a fracturable K-input LUT, an optional full adder on a ripple carry chain, and an optional output flip-flop.
- Configuration is loaded serially through an internal scan register controlled by an FSM, instead of a parallel cfg bus.
- Sits in fpga_top as the programmable tile; the config chain is daisy-chained by the tile controller.

---
 rtl/logic_cluster_pkg.sv | 21 ++
 rtl/logic_cluster_ble.sv | 71 +++++++
 rtl/logic_cluster.sv | 114 +++++++++++
 tb/tb_logic_cluster.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/logic_cluster_pkg.sv
// Shared BLE config-field layout, sizing helper and configuration FSM states
// for the parametrised logic cluster.
package logic_cluster_pkg;

  // LUT memory starts at bit 0; the control-bit offsets count up from bit 2**K.
  localparam int LUT_LSB     = 0;
  localparam int ADD_EN_BIT  = 0;
  localparam int FF_EN_BIT   = 1;
  localparam int FF_INIT_BIT = 2;

  function automatic int ble_cfg_width(input int k);
    return (2 ** k) + 3;
  endfunction

  typedef enum logic [1:0] {
    SHIFT = 2'd0,
    INIT  = 2'd1,
    RUN   = 2'd2
  } cluster_state_t;

endpackage

// File: rtl/logic_cluster_ble.sv
// One basic logic element: a fracturable K-input LUT, a full adder on the
// carry chain, and an output flop with clock enable and init load.
module logic_ble
  import logic_cluster_pkg::*;
#(
  parameter int K = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [ble_cfg_width(K)-1:0] cfg,
  input  logic [K-1:0]                in_i,
  input  logic                        c_in,
  input  logic                        ff_clr,
  input  logic                        ff_load,
  input  logic                        ff_cap,
  output logic                        c_out,
  output logic                        ble_out
);

  localparam int LUT_SIZE = 2 ** K;

  logic [LUT_SIZE-1:0] mem;
  logic                adder_en;
  logic                ff_en;
  logic                ff_init;
  logic                a;
  logic                b;
  logic                comb;
  logic                ff_d;
  logic                ff_q;

  assign mem      = cfg[LUT_LSB +: LUT_SIZE];
  assign adder_en = cfg[LUT_SIZE + ADD_EN_BIT];
  assign ff_en    = cfg[LUT_SIZE + FF_EN_BIT];
  assign ff_init  = cfg[LUT_SIZE + FF_INIT_BIT];

  // In adder mode the LUT splits into two (K-1)-input halves feeding a and b.
  always_comb begin
    a = mem[{1'b0, in_i[K-2:0]}];
    b = mem[{1'b1, in_i[K-2:0]}];
    if (adder_en) begin
      comb  = a ^ b ^ c_in;
      c_out = (a & b) | (a & c_in) | (b & c_in);
    end else begin
      comb  = mem[in_i];
      c_out = c_in;
    end
  end

  always_comb begin
    ff_d = ff_q;
    if (ff_clr) begin
      ff_d = 1'b0;
    end else if (ff_load) begin
      ff_d = ff_init;
    end else if (ff_cap) begin
      ff_d = comb;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= 1'b0;
    end else begin
      ff_q <= ff_d;
    end
  end

  assign ble_out = ff_en ? ff_q : comb;

endmodule

// File: rtl/logic_cluster.sv
// Cluster of N BLEs on a ripple carry chain, configured through a serial scan
// register whose load sequence is governed by a SHIFT/INIT/RUN state machine.
module logic_cluster
  import logic_cluster_pkg::*;
#(
  parameter int K = 4,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_en,
  input  logic           cfg_din,
  output logic           cfg_ready,
  output logic           cfg_valid,
  input  logic           ce,
  input  logic [N*K-1:0] in,
  input  logic           cin,
  output logic [N-1:0]   out,
  output logic           cout
);

  localparam int BLE_CFG_W = ble_cfg_width(K);
  localparam int CFG_W     = N * BLE_CFG_W;
  localparam int CNT_W     = $clog2(CFG_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  cluster_state_t   state_q;
  cluster_state_t   state_d;
  logic [CFG_W-1:0] sr_q;
  logic [CFG_W-1:0] sr_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [N:0]       carry;
  logic [N-1:0]     ble_out;
  logic             ff_clr;
  logic             ff_load;
  logic             ff_cap;

  // A bit taken in RUN is the first bit of a fresh load, hence the counter restarts at 1.
  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    case (state_q)
      SHIFT: begin
        if (cfg_en) begin
          sr_d = {sr_q[CFG_W-2:0], cfg_din};
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = INIT;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end
      INIT: begin
        state_d = RUN;
      end
      RUN: begin
        if (cfg_en) begin
          sr_d    = {sr_q[CFG_W-2:0], cfg_din};
          cnt_d   = CNT_ONE;
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = SHIFT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SHIFT;
      sr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cfg_ready = (state_q != INIT);
  assign cfg_valid = (state_q == RUN);
  assign ff_clr    = (state_q == SHIFT);
  assign ff_load   = (state_q == INIT);
  assign ff_cap    = (state_q == RUN) && ce;

  assign carry[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_ble
    logic_ble #(
      .K(K)
    ) u_ble (
      .clk    (clk),
      .rst_n  (rst_n),
      .cfg    (sr_q[i*BLE_CFG_W +: BLE_CFG_W]),
      .in_i   (in[i*K +: K]),
      .c_in   (carry[i]),
      .ff_clr (ff_clr),
      .ff_load(ff_load),
      .ff_cap (ff_cap),
      .c_out  (carry[i+1]),
      .ble_out(ble_out[i])
    );
  end

  // Outputs are only meaningful once a complete configuration is live.
  assign out  = cfg_valid ? ble_out : '0;
  assign cout = cfg_valid & carry[N];

endmodule

// File: tb/tb_logic_cluster.sv
// Scoreboard bench for logic_cluster (K=4, N=2): stimulus queues expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_logic_cluster;

  localparam int K     = 4;
  localparam int N     = 2;
  localparam int CFG_W = 38;

  logic           clk;
  logic           rst_n;
  logic           cfg_en;
  logic           cfg_din;
  logic           cfg_ready;
  logic           cfg_valid;
  logic           ce;
  logic [N*K-1:0] in;
  logic           cin;
  logic [N-1:0]   out;
  logic           cout;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    int         due;
    logic [1:0] out;
    logic       cout;
    logic       valid;
    logic       ready;
  } exp_t;

  exp_t sb[$];

  logic [CFG_W-1:0] cfg_a;
  logic [CFG_W-1:0] cfg_b;
  logic [CFG_W-1:0] cfg_c;
  logic [CFG_W-1:0] cfg_d;
  logic [CFG_W-1:0] cfg_ones;

  logic_cluster #(
    .K(K),
    .N(N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_en   (cfg_en),
    .cfg_din  (cfg_din),
    .cfg_ready(cfg_ready),
    .cfg_valid(cfg_valid),
    .ce       (ce),
    .in       (in),
    .cin      (cin),
    .out      (out),
    .cout     (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [18:0] ble_field(input logic ff_init, input logic ff_en,
                                            input logic add_en, input logic [15:0] mem);
    return {ff_init, ff_en, add_en, mem};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [7:0] v, input logic c, input logic e);
    in  = v;
    cin = c;
    ce  = e;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] o, input logic co,
                             input logic v, input logic r);
    exp_t e;
    e.name  = name;
    e.due   = cyc;
    e.out   = o;
    e.cout  = co;
    e.valid = v;
    e.ready = r;
    sb.push_back(e);
  endtask

  // Shifts the n least-significant bits of v, MSB first.
  task automatic load_bits(input logic [CFG_W-1:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      cfg_en  = 1'b1;
      cfg_din = v[i];
      tick();
    end
    cfg_en  = 1'b0;
    cfg_din = 1'b0;
  endtask

  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (e.due != cyc) begin
        errors++;
        $display("[TB] FAIL %s: sampled late (due cycle %0d, now %0d)", e.name, e.due, cyc);
      end else if ({out, cout, cfg_valid, cfg_ready} !== {e.out, e.cout, e.valid, e.ready}) begin
        errors++;
        $display("[TB] FAIL %s: got out=%b cout=%b valid=%b ready=%b, want out=%b cout=%b valid=%b ready=%b",
                 e.name, out, cout, cfg_valid, cfg_ready, e.out, e.cout, e.valid, e.ready);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    cfg_a    = {ble_field(1'b0, 1'b0, 1'b0, 16'h0000), ble_field(1'b0, 1'b0, 1'b0, 16'h8000)};
    cfg_b    = {ble_field(1'b0, 1'b0, 1'b1, 16'hCCAA), ble_field(1'b0, 1'b0, 1'b1, 16'hCCAA)};
    cfg_c    = {ble_field(1'b0, 1'b0, 1'b0, 16'h0000), ble_field(1'b0, 1'b0, 1'b1, 16'hCCAA)};
    cfg_d    = {ble_field(1'b0, 1'b0, 1'b0, 16'h0002), ble_field(1'b1, 1'b1, 1'b0, 16'h0000)};
    cfg_ones = '1;

    rst_n   = 1'b0;
    cfg_en  = 1'b0;
    cfg_din = 1'b0;
    applyStimulus(8'hFF, 1'b1, 1'b0);
    tick();
    tick();
    checkOutput("reset", 2'b00, 1'b0, 1'b0, 1'b1);
    tick();
    rst_n = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    tick();

    // Partial load interrupted by reset must be forgotten.
    load_bits(cfg_ones, 10);
    rst_n = 1'b0;
    applyStimulus(8'hFF, 1'b1, 1'b0);
    checkOutput("midload_reset", 2'b00, 1'b0, 1'b0, 1'b1);
    tick();
    rst_n = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    tick();

    load_bits(cfg_a, CFG_W);
    checkOutput("a_init", 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    checkOutput("a_run", 2'b00, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h0F, 1'b0, 1'b0);
    checkOutput("and4_f", 2'b01, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h0E, 1'b0, 1'b0);
    checkOutput("and4_e", 2'b00, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h0F, 1'b1, 1'b0);
    checkOutput("lut_carry_pass", 2'b01, 1'b1, 1'b1, 1'b1);

    // Reconfigure straight from RUN: the first bit is taken in RUN.
    cfg_en  = 1'b1;
    cfg_din = cfg_b[CFG_W-1];
    tick();
    cfg_en  = 1'b0;
    checkOutput("reconf_drop", 2'b00, 1'b0, 1'b0, 1'b1);
    load_bits(cfg_b, CFG_W - 1);
    checkOutput("b_init", 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h13, 1'b0, 1'b0);
    checkOutput("add_3p1", 2'b00, 1'b1, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h01, 1'b1, 1'b0);
    checkOutput("add_1p0c1", 2'b10, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(8'hB2, 1'b1, 1'b0);
    checkOutput("add_2p3c1", 2'b10, 1'b1, 1'b1, 1'b1);
    tick();

    load_bits(cfg_c, CFG_W);
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("c_init", 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(8'h03, 1'b0, 1'b0);
    checkOutput("carry_bypass", 2'b00, 1'b1, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h01, 1'b0, 1'b0);
    checkOutput("c_sum", 2'b01, 1'b0, 1'b1, 1'b1);
    tick();

    // cfg_en stays high through INIT; that bit must not reach the scan register.
    load_bits(cfg_d, CFG_W);
    cfg_en  = 1'b1;
    cfg_din = 1'b1;
    applyStimulus(8'h00, 1'b0, 1'b0);
    checkOutput("d_init", 2'b00, 1'b0, 1'b0, 1'b0);
    tick();
    cfg_en  = 1'b0;
    cfg_din = 1'b0;
    checkOutput("ff_init_run", 2'b01, 1'b0, 1'b1, 1'b1);
    tick();
    checkOutput("ff_hold", 2'b01, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h10, 1'b0, 1'b0);
    checkOutput("lut_after_init", 2'b11, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h10, 1'b0, 1'b1);
    checkOutput("ce_pre", 2'b11, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h10, 1'b0, 1'b0);
    checkOutput("ce_capture", 2'b10, 1'b0, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h20, 1'b0, 1'b0);
    checkOutput("lut_no_init_shift", 2'b00, 1'b0, 1'b1, 1'b1);
    tick();
    tick();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL pending: %0d expectations never sampled, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
